// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: shared encodings for the multi-cycle HI/LO sequencer.
// Holds the op codes seen from ID/EX, the sequencer state encoding,
// handshake level names, and small op-decode helpers.
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    MdNone  = 3'd0,
    MdDiv   = 3'd1,
    MdDivu  = 3'd2,
    MdMadd  = 3'd3,
    MdMaddu = 3'd4,
    MdMsub  = 3'd5,
    MdMsubu = 3'd6
  } md_op_e;

  typedef enum logic [2:0] {
    MdIdle    = 3'd0,
    MdDivBusy = 3'd1,
    MdMacMul  = 3'd2,
    MdMacAcc  = 3'd3,
    MdDone    = 3'd4
  } md_state_e;

  localparam logic StallReq       = 1'b1;
  localparam logic NoStallReq     = 1'b0;
  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;
  localparam logic DivResultReady = 1'b1;

  // True for any divide op.
  function automatic logic op_is_div(input logic [2:0] op);
    logic r;
    case (op)
      MdDiv, MdDivu: r = 1'b1;
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

  // True for any multiply-accumulate op.
  function automatic logic op_is_mac(input logic [2:0] op);
    logic r;
    case (op)
      MdMadd, MdMaddu, MdMsub, MdMsubu: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the subtracting multiply-accumulate ops.
  function automatic logic op_is_sub(input logic [2:0] op);
    logic r;
    case (op)
      MdMsub, MdMsubu: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the signed multiply-accumulate ops.
  function automatic logic op_is_smac(input logic [2:0] op);
    logic r;
    case (op)
      MdMadd, MdMsub: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_ctrl_mul32x32.sv
// mul32x32: combinational 32x32->64 multiplier.
// Ports: signed_i selects two's-complement operands, a_i/b_i are the
// operands, p_o is the 64-bit product.
// Both operands are extended to 64 bits first; the low 64 bits of the
// extended product are the exact result in either mode.
module mul32x32 (
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] p_o
);

  logic [63:0] a_ext_s;
  logic [63:0] b_ext_s;

  assign a_ext_s = signed_i ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
  assign b_ext_s = signed_i ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
  assign p_o     = a_ext_s * b_ext_s;

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: EX-stage sequencer for DIV/DIVU and MADD/MADDU/MSUB/MSUBU.
// Ports: valid_i/op_i/reg1_i/reg2_i/hi_i/lo_i come from ID/EX; flush_i and
// ex_stall_i from pipeline control; div_* is the divider start/annul/ready
// handshake; stallreq_o freezes the pipeline while an op runs; whilo_o with
// hi_o/lo_o is the single HI/LO write presented in the DONE state.
// Outputs are decoded from state and inputs and forced low during reset.
module md_ctrl
  import md_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush_i,
  input  logic        ex_stall_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_e   state_r;
  md_state_e   state_s;
  logic [63:0] prod_q;
  logic [63:0] res_q;
  logic [63:0] prod_s;
  logic [63:0] res_next_s;
  logic        load_prod_s;
  logic        load_res_s;
  logic        load_flags_s;
  logic        sign_r;
  logic        sub_r;
  logic        start_s;
  logic        annul_s;
  logic        dsigned_s;
  logic        stall_s;
  logic        whilo_s;
  logic [63:0] hilo_s;
  logic        opd_en_s;

  mul32x32 u_mul (
    .signed_i (op_is_smac(op_i)),
    .a_i      (reg1_i),
    .b_i      (reg2_i),
    .p_o      (prod_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= MdIdle;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: product, result and the per-op flags captured at launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= 64'd0;
      res_q  <= 64'd0;
      sign_r <= 1'b0;
      sub_r  <= 1'b0;
    end else begin
      if (load_prod_s) prod_q <= prod_s;
      if (load_res_s)  res_q  <= res_next_s;
      if (load_flags_s) begin
        sign_r <= (op_i == MdDiv);
        sub_r  <= op_is_sub(op_i);
      end
    end
  end

  // Next-state and output decode; flush overrides every state.
  always_comb begin
    state_s      = state_r;
    load_prod_s  = 1'b0;
    load_res_s   = 1'b0;
    load_flags_s = 1'b0;
    res_next_s   = res_q;
    start_s      = DivStop;
    annul_s      = 1'b0;
    dsigned_s    = 1'b0;
    stall_s      = NoStallReq;
    whilo_s      = 1'b0;
    hilo_s       = 64'd0;
    if (flush_i) begin
      state_s = MdIdle;
      annul_s = (state_r == MdDivBusy);
    end else begin
      case (state_r)
        MdIdle: begin
          if (valid_i && op_is_div(op_i)) begin
            start_s      = DivStart;
            dsigned_s    = (op_i == MdDiv);
            stall_s      = StallReq;
            load_flags_s = 1'b1;
            state_s      = MdDivBusy;
          end else if (valid_i && op_is_mac(op_i)) begin
            load_prod_s  = 1'b1;
            load_flags_s = 1'b1;
            stall_s      = StallReq;
            state_s      = MdMacMul;
          end else begin
            state_s = MdIdle;
          end
        end
        MdDivBusy: begin
          start_s   = DivStart;
          dsigned_s = sign_r;
          stall_s   = StallReq;
          if (div_ready_i == DivResultReady) begin
            load_res_s = 1'b1;
            res_next_s = div_result_i;
            state_s    = MdDone;
          end else begin
            state_s = MdDivBusy;
          end
        end
        MdMacMul: begin
          stall_s    = StallReq;
          load_res_s = 1'b1;
          res_next_s = sub_r ? ({hi_i, lo_i} - prod_q) : ({hi_i, lo_i} + prod_q);
          state_s    = MdMacAcc;
        end
        MdMacAcc: begin
          stall_s = StallReq;
          state_s = MdDone;
        end
        MdDone: begin
          // Never launches from here, so a held instruction is not re-run.
          whilo_s = 1'b1;
          hilo_s  = res_q;
          if (ex_stall_i) begin
            state_s = MdDone;
          end else begin
            state_s = MdIdle;
          end
        end
        default: begin
          state_s = MdIdle;
        end
      endcase
    end
  end

  // Operands are only presented while a divide or MAC is in flight.
  assign opd_en_s = ~rst & ((state_r != MdIdle) | start_s | load_prod_s);

  assign div_start_o   = ~rst & start_s;
  assign div_annul_o   = ~rst & annul_s;
  assign div_signed_o  = ~rst & dsigned_s;
  assign stallreq_o    = ~rst & stall_s;
  assign whilo_o       = ~rst & whilo_s;
  assign hi_o          = rst ? 32'd0 : hilo_s[63:32];
  assign lo_o          = rst ? 32'd0 : hilo_s[31:0];
  assign div_opdata1_o = opd_en_s ? reg1_i : 32'd0;
  assign div_opdata2_o = opd_en_s ? reg2_i : 32'd0;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed bench for md_ctrl with a behavioural divider.
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  localparam int DLAT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
  logic        flush_i, ex_stall_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic        stallreq_o, whilo_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  md_ctrl dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .hi_i(hi_i), .lo_i(lo_i),
    .flush_i(flush_i), .ex_stall_i(ex_stall_i),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o), .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o), .stallreq_o(stallreq_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Behavioural divider: idle -> busy (DLAT cycles) -> ready until start drops.
  logic [1:0]  dv_st;
  int          dv_cnt;
  logic [63:0] dv_res;

  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = a; sb = b; sq = sa / sb; sr = sa % sb;
      return {sr, sq};
    end
    uq = a / b; ur = a % b;
    return {ur, uq};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_st <= 2'd0; dv_cnt <= 0; dv_res <= 64'd0;
    end else begin
      case (dv_st)
        2'd0: if (div_start_o && !div_annul_o) begin
          dv_st <= 2'd1; dv_cnt <= 0;
          dv_res <= div_model(div_signed_o, div_opdata1_o, div_opdata2_o);
        end
        2'd1: if (div_annul_o) dv_st <= 2'd0;
              else if (dv_cnt == DLAT - 1) dv_st <= 2'd2;
              else dv_cnt <= dv_cnt + 1;
        2'd2: if (!div_start_o) dv_st <= 2'd0;
        default: dv_st <= 2'd0;
      endcase
    end
  end
  assign div_ready_i  = (dv_st == 2'd2);
  assign div_result_i = (dv_st == 2'd2) ? dv_res : 64'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l);
    valid_i = v; op_i = op; reg1_i = a; reg2_i = b; hi_i = h; lo_i = l;
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [31:0] r1, r2, hi, lo;
    logic        fl, es;
    logic        e_stall, e_whilo;
    logic [63:0] e_res;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] hi, input logic [31:0] lo, input logic fl, input logic es,
                              input logic st, input logic wh, input logic [63:0] res);
    vec_t t;
    t.v = v; t.op = op; t.r1 = r1; t.r2 = r2; t.hi = hi; t.lo = lo;
    t.fl = fl; t.es = es; t.e_stall = st; t.e_whilo = wh; t.e_res = res;
    return t;
  endfunction

  // Launch cycle + MAC_MUL + MAC_ACC stall, then DONE, then back to idle.
  task automatic add_mac(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l, input logic [63:0] res);
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1'b1, op, a, b, h, l, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0));
    vecs.push_back(mk(1'b1, op, a, b, h, l, 1'b0, 1'b0, 1'b0, 1'b1, res));
    vecs.push_back(mk(1'b0, MdNone, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0));
  endtask

  // Full divide: launch, wait for DONE, check result, retire.
  task automatic run_div(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res);
    int n;
    logic stall_ok;
    step(); drive(1'b1, op, a, b, 32'd0, 32'd0);
    @(negedge clk);
    chk({nm, " launch start/stall/signed"}, {61'd0, div_start_o, stallreq_o, div_signed_o},
        {61'd0, 1'b1, 1'b1, (op == MdDiv)});
    chk({nm, " opdata"}, {div_opdata1_o, div_opdata2_o}, {a, b});
    n = 0; stall_ok = 1'b1;
    while (!whilo_o && n < 100) begin
      step(); @(negedge clk);
      if (!whilo_o && !(stallreq_o && div_start_o)) stall_ok = 1'b0;
      n++;
    end
    chk({nm, " reached DONE in bound"}, {63'd0, whilo_o}, 64'd1);
    chk({nm, " stall+start held while busy"}, {63'd0, stall_ok}, 64'd1);
    chk({nm, " hi/lo"}, {hi_o, lo_o}, res);
    chk({nm, " DONE stall/start"}, {62'd0, stallreq_o, div_start_o}, 64'd0);
    step(); drive(1'b0, MdNone, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk({nm, " after DONE whilo/start/stall"}, {61'd0, whilo_o, div_start_o, stallreq_o}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; ex_stall_i = 1'b0;
    drive(1'b1, MdDiv, 32'd100, 32'd7, 32'd1, 32'd2);
    #3;
    chk("reset ctrl outputs zero", {59'd0, div_start_o, div_annul_o, div_signed_o, stallreq_o, whilo_o}, 64'd0);
    chk("reset hi/lo zero", {hi_o, lo_o}, 64'd0);
    chk("reset opdata zero", {div_opdata1_o, div_opdata2_o}, 64'd0);
    step(); step();
    rst = 1'b0; drive(1'b0, MdNone, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("idle outputs zero", {59'd0, div_start_o, div_annul_o, div_signed_o, stallreq_o, whilo_o}, 64'd0);

    // Table: MAC sequences and a flush in MAC_MUL.
    add_mac(MdMadd,  32'hFFFFFFFE, 32'd3,        32'd0, 32'd5,        64'hFFFFFFFF_FFFFFFFF);
    add_mac(MdMsubu, 32'hFFFFFFFF, 32'd2,        32'd0, 32'd0,        64'hFFFFFFFE_00000002);
    add_mac(MdMaddu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 64'h00000000_00000000);
    add_mac(MdMsub,  32'hFFFFFFFD, 32'hFFFFFFFC, 32'd0, 32'd10,       64'hFFFFFFFF_FFFFFFFE);
    vecs.push_back(mk(1'b1, MdMadd, 32'd4, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0));
    vecs.push_back(mk(1'b1, MdMadd, 32'd4, 32'd4, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0));
    vecs.push_back(mk(1'b0, MdNone, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0));
    add_mac(MdMaddu, 32'd6, 32'd7, 32'd0, 32'd0, 64'h00000000_0000002A);

    foreach (vecs[i]) begin
      step();
      drive(vecs[i].v, vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].hi, vecs[i].lo);
      flush_i = vecs[i].fl; ex_stall_i = vecs[i].es;
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), {63'd0, stallreq_o}, {63'd0, vecs[i].e_stall});
      chk($sformatf("vec%0d whilo", i), {63'd0, whilo_o}, {63'd0, vecs[i].e_whilo});
      chk($sformatf("vec%0d hilo", i), {hi_o, lo_o}, vecs[i].e_res);
      chk($sformatf("vec%0d div_start", i), {63'd0, div_start_o}, 64'd0);
    end
    flush_i = 1'b0;

    // Divides, including divide-by-zero pass-through.
    run_div("div -7/2", MdDiv, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_div("divu 100/0", MdDivu, 32'd100, 32'd0, 64'd0);
    run_div("divu 100/7", MdDivu, 32'd100, 32'd7, {32'd2, 32'd14});

    // Flush in the 10th DIV_BUSY cycle.
    step(); drive(1'b1, MdDiv, 32'd50, 32'd3, 32'd0, 32'd0);
    for (int k = 1; k <= 9; k++) step();
    @(negedge clk);
    chk("flush pre: busy stall", {63'd0, stallreq_o}, 64'd1);
    step(); flush_i = 1'b1;
    @(negedge clk);
    chk("flush cycle annul", {63'd0, div_annul_o}, 64'd1);
    chk("flush cycle whilo/stall/start", {61'd0, whilo_o, stallreq_o, div_start_o}, 64'd0);
    step(); flush_i = 1'b0; drive(1'b0, MdNone, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("after flush idle", {60'd0, whilo_o, stallreq_o, div_start_o, div_annul_o}, 64'd0);
    for (int k = 0; k < 20; k++) begin
      step(); @(negedge clk);
      if (whilo_o) break;
    end
    chk("no write after flush", {63'd0, whilo_o}, 64'd0);
    run_div("div -100/7 after flush", MdDiv, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);

    // ex_stall_i holds DONE for 3 extra cycles without relaunch.
    step(); drive(1'b1, MdMadd, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd5);
    step(); step(); step(); ex_stall_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) ex_stall_i = 1'b0;
      @(negedge clk);
      chk($sformatf("hold%0d whilo/stall", k), {62'd0, whilo_o, stallreq_o}, {62'd0, 1'b1, 1'b0});
      chk($sformatf("hold%0d hilo", k), {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFF);
      if (k < 3) step();
    end
    step(); drive(1'b0, MdNone, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("after hold idle", {62'd0, whilo_o, stallreq_o}, 64'd0);

    // Asynchronous reset mid DIV_BUSY.
    step(); drive(1'b1, MdDiv, 32'd100, 32'd7, 32'd0, 32'd0);
    step(); step(); step();
    @(negedge clk);
    chk("pre-reset busy", {62'd0, stallreq_o, div_start_o}, 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("async reset ctrl zero", {59'd0, div_start_o, div_annul_o, div_signed_o, stallreq_o, whilo_o}, 64'd0);
    chk("async reset data zero", {hi_o, lo_o, div_opdata1_o[0], div_opdata2_o[0]}, 66'd0);
    step(); rst = 1'b0; drive(1'b0, MdNone, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("post-reset idle", {62'd0, stallreq_o, div_start_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
